// File: rtl/itc_pkg.sv
// Shared types, dequantisation table and helpers for the inverse transform coder.
package itc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEQ,
    ROW,
    COL,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    CLS_A,
    CLS_B,
    CLS_C
  } pos_class_t;

  localparam int unsigned QP_MAX = 51;

  // Flat dequant scale per QP%6, columns ordered {a, b, c}
  localparam logic [4:0] V [6][3] = '{
    '{5'd10, 5'd16, 5'd13},
    '{5'd11, 5'd18, 5'd14},
    '{5'd13, 5'd20, 5'd16},
    '{5'd14, 5'd23, 5'd18},
    '{5'd16, 5'd25, 5'd20},
    '{5'd18, 5'd29, 5'd23}
  };

  // Position class of a raster index: both even -> a, both odd -> b, mixed -> c
  function automatic pos_class_t pos_class(input logic [3:0] idx);
    logic row_odd;
    logic col_odd;
    row_odd = idx[2];
    col_odd = idx[0];
    if (!row_odd && !col_odd) return CLS_A;
    if (row_odd && col_odd)   return CLS_B;
    return CLS_C;
  endfunction

  // Table lookup; QP%6 never exceeds 5, the guard only keeps the index in range
  function automatic logic [4:0] dequant_v(input logic [2:0] qmod, input pos_class_t cls);
    if (qmod > 3'd5) return 5'd0;
    return V[qmod][cls];
  endfunction

endpackage

// File: rtl/inverse_butterfly4.sv
// Combinational 4-point H.264 inverse integer transform core.
module inverse_butterfly4 #(
  parameter int unsigned BIT_LENGTH = 31
) (
  input  logic signed [BIT_LENGTH:0] x0,
  input  logic signed [BIT_LENGTH:0] x1,
  input  logic signed [BIT_LENGTH:0] x2,
  input  logic signed [BIT_LENGTH:0] x3,
  output logic signed [BIT_LENGTH:0] y0,
  output logic signed [BIT_LENGTH:0] y1,
  output logic signed [BIT_LENGTH:0] y2,
  output logic signed [BIT_LENGTH:0] y3
);

  logic signed [BIT_LENGTH:0] e;
  logic signed [BIT_LENGTH:0] f;
  logic signed [BIT_LENGTH:0] g;
  logic signed [BIT_LENGTH:0] h;

  // Even/odd butterfly with arithmetic half-weights on the odd inputs
  always_comb begin
    e  = x0 + x2;
    f  = x0 - x2;
    g  = (x1 >>> 1) - x3;
    h  = x1 + (x3 >>> 1);
    y0 = e + h;
    y1 = f + g;
    y2 = f - g;
    y3 = e - h;
  end

endmodule

// File: rtl/inverse_transform_coder.sv
// Dequantise a 4x4 level block, inverse transform it and hand the residuals downstream.
module inverse_transform_coder
  import itc_pkg::*;
#(
  parameter int unsigned BIT_LENGTH = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [5:0]            QP,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIT_LENGTH:0]   coeffs    [16],
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIT_LENGTH:0]   residuals [16]
);

  localparam int unsigned W = BIT_LENGTH + 1;
  localparam logic signed [W-1:0] ROUND_BIAS = W'(32);

  state_t              state;
  logic [5:0]          qp_r;
  logic signed [W-1:0] w       [16];
  logic signed [W-1:0] deq     [16];
  logic signed [W-1:0] row_res [16];
  logic signed [W-1:0] col_res [16];
  logic signed [W-1:0] rnd     [16];
  logic [2:0]          qp_mod;
  logic [3:0]          qp_div;

  // Split the clamped QP into table row and shift amount
  always_comb begin
    qp_mod = 3'(qp_r % 6'd6);
    qp_div = 4'(qp_r / 6'd6);
  end

  // Flat-scaling dequantisation of the latched levels
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      deq[i] = (w[i] * $signed(W'(dequant_v(qp_mod, pos_class(4'(i)))))) <<< qp_div;
    end
  end

  // Four butterflies shared by the row pass and the column pass
  for (genvar k = 0; k < 4; k++) begin : g_bfly
    logic signed [W-1:0] x [4];
    logic signed [W-1:0] y [4];
    for (genvar j = 0; j < 4; j++) begin : g_tap
      assign x[j]             = (state == COL) ? w[4*j+k] : w[4*k+j];
      assign row_res[4*k+j]   = y[j];
      assign col_res[4*j+k]   = y[j];
    end
    inverse_butterfly4 #(.BIT_LENGTH(BIT_LENGTH)) u_bfly (
      .x0 (x[0]),
      .x1 (x[1]),
      .x2 (x[2]),
      .x3 (x[3]),
      .y0 (y[0]),
      .y1 (y[1]),
      .y2 (y[2]),
      .y3 (y[3])
    );
  end

  // Final (z+32)>>>6 floor rounding of the column-pass result
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      rnd[i] = (col_res[i] + ROUND_BIAS) >>> 6;
    end
  end

  // Control FSM and datapath registers; w is reused for levels, dequant and row results
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      qp_r      <= '0;
      for (int i = 0; i < 16; i++) begin
        w[i]         <= '0;
        residuals[i] <= '0;
      end
    end else if (enable) begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            for (int i = 0; i < 16; i++) w[i] <= coeffs[i];
            qp_r     <= (QP > 6'(QP_MAX)) ? 6'(QP_MAX) : QP;
            in_ready <= 1'b0;
            state    <= DEQ;
          end
        end
        DEQ: begin
          for (int i = 0; i < 16; i++) w[i] <= deq[i];
          state <= ROW;
        end
        ROW: begin
          for (int i = 0; i < 16; i++) w[i] <= row_res[i];
          state <= COL;
        end
        COL: begin
          for (int i = 0; i < 16; i++) residuals[i] <= rnd[i];
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inverse_transform_coder.sv
// Directed bench for inverse_transform_coder: vector table plus control corner cases.
module tb_inverse_transform_coder;

  localparam int unsigned BL = 31;
  localparam int NVEC = 7;

  typedef struct packed {
    logic [5:0]         qp;
    logic [15:0][31:0]  c;
    logic [15:0][31:0]  r;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [5:0]  QP;
  logic        in_valid;
  logic        in_ready;
  logic [BL:0] coeffs    [16];
  logic        out_valid;
  logic        out_ready;
  logic [BL:0] residuals [16];

  int checks;
  int fails;
  vec_t vecs [NVEC];

  inverse_transform_coder #(.BIT_LENGTH(BL)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .QP        (QP),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .coeffs    (coeffs),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .residuals (residuals)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, $signed(act), act, $signed(exp), exp);
    end
  endtask

  task automatic check_res(input string name, input logic [15:0][31:0] exp);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("%s res[%0d]", name, i), residuals[i], exp[i]);
    end
  endtask

  // Present a block at a negedge; acceptance happens on the following posedge
  task automatic accept(input vec_t v);
    @(negedge clk);
    check("in_ready before accept", 32'(in_ready), 32'd1);
    QP       = v.qp;
    for (int i = 0; i < 16; i++) coeffs[i] = v.c[i];
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Count negedges after the accept negedge until out_valid, bounded
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic release_block(input string name);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, " out_valid after handoff"}, 32'(out_valid), 32'd0);
    check({name, " in_ready after handoff"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int n;
    logic [15:0][31:0] held;
    logic [15:0][31:0] zeros;

    checks    = 0;
    fails     = 0;
    reset     = 1'b1;
    enable    = 1'b1;
    QP        = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) coeffs[i] = '0;
    zeros = '0;

    // Vector table: QP, levels, expected residuals
    for (int v = 0; v < NVEC; v++) vecs[v] = '0;
    vecs[0].qp = 6'd28;
    vecs[1].qp = 6'd0;  vecs[1].c[0] = 32'd32;
    for (int i = 0; i < 16; i++) vecs[1].r[i] = 32'd5;
    vecs[2].qp = 6'd0;  vecs[2].c[0] = 32'(-32);
    for (int i = 0; i < 16; i++) vecs[2].r[i] = 32'(-5);
    vecs[3].qp = 6'd24; vecs[3].c[0] = 32'd1;
    for (int i = 0; i < 16; i++) vecs[3].r[i] = 32'd3;
    // QP 60 clamps to 51: scale a=14 (51%6=3), shift 8 -> 3584 -> 56
    vecs[4].qp = 6'd60; vecs[4].c[0] = 32'd1;
    for (int i = 0; i < 16; i++) vecs[4].r[i] = 32'd56;
    vecs[5].qp = 6'd0;  vecs[5].c[1] = 32'd64;
    for (int rr = 0; rr < 4; rr++) begin
      vecs[5].r[4*rr+0] = 32'd13;
      vecs[5].r[4*rr+1] = 32'd7;
      vecs[5].r[4*rr+2] = 32'(-6);
      vecs[5].r[4*rr+3] = 32'(-13);
    end
    // Class b at (1,1), QP 6: 4*16<<1 = 128
    vecs[6].qp = 6'd6;  vecs[6].c[5] = 32'd4;
    vecs[6].r[0]  = 32'd2;   vecs[6].r[1]  = 32'd1;  vecs[6].r[2]  = 32'(-1); vecs[6].r[3]  = 32'(-2);
    vecs[6].r[4]  = 32'd1;   vecs[6].r[5]  = 32'd1;  vecs[6].r[6]  = 32'd0;   vecs[6].r[7]  = 32'(-1);
    vecs[6].r[8]  = 32'(-1); vecs[6].r[9]  = 32'd0;  vecs[6].r[10] = 32'd1;   vecs[6].r[11] = 32'd1;
    vecs[6].r[12] = 32'(-2); vecs[6].r[13] = 32'(-1); vecs[6].r[14] = 32'd1;  vecs[6].r[15] = 32'd2;

    repeat (2) @(negedge clk);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check_res("reset", zeros);
    reset = 1'b0;

    // Table-driven blocks
    for (int v = 0; v < NVEC; v++) begin
      accept(vecs[v]);
      check($sformatf("vec%0d in_ready busy", v), 32'(in_ready), 32'd0);
      wait_valid(n);
      check($sformatf("vec%0d latency", v), 32'(n), 32'd3);
      check_res($sformatf("vec%0d", v), vecs[v].r);
      release_block($sformatf("vec%0d", v));
    end

    // Stall in DONE: outputs hold, new input ignored, residuals retained after handoff
    accept(vecs[5]);
    wait_valid(n);
    check("hold latency", 32'(n), 32'd3);
    for (int i = 0; i < 16; i++) coeffs[i] = 32'd99;
    QP       = 6'd10;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("hold out_valid c%0d", c), 32'(out_valid), 32'd1);
      check($sformatf("hold in_ready c%0d", c), 32'(in_ready), 32'd0);
      check($sformatf("hold res[3] c%0d", c), residuals[3], 32'(-13));
    end
    in_valid = 1'b0;
    check_res("hold", vecs[5].r);
    release_block("hold");
    repeat (2) @(negedge clk);
    check("idle after hold out_valid", 32'(out_valid), 32'd0);
    check_res("retained", vecs[5].r);

    // Enable low for 3 cycles in ROW stretches latency by 3
    accept(vecs[6]);
    @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("stall out_valid frozen", 32'(out_valid), 32'd0);
    check("stall in_ready frozen", 32'(in_ready), 32'd0);
    enable = 1'b1;
    wait_valid(n);
    check("stall latency", 32'(n + 4), 32'd6);
    check_res("stall", vecs[6].r);
    // No handoff while enable is low
    out_ready = 1'b1;
    enable    = 1'b0;
    @(negedge clk);
    check("handoff blocked by enable", 32'(out_valid), 32'd1);
    out_ready = 1'b0;
    enable    = 1'b1;
    release_block("stall");

    // Reset while in COL aborts the block
    accept(vecs[1]);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort in_ready", 32'(in_ready), 32'd1);
    check_res("abort", zeros);
    held = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      held[0] = held[0] | 32'(out_valid);
    end
    check("abort never delivered", held[0], 32'd0);

    // Recovery after abort
    accept(vecs[2]);
    wait_valid(n);
    check("recover latency", 32'(n), 32'd3);
    check_res("recover", vecs[2].r);
    release_block("recover");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
